// File: rtl/menu_text_renderer.sv
// Menu text renderer: 80x9 character buffer written by the config FSM, scanned
// against the raster through an external 2-cycle font ROM, with row highlight.
module menu_text_renderer #(
    parameter int unsigned TEXT_COLS     = 80,
    parameter int unsigned TEXT_ROWS     = 9,
    parameter int unsigned SCALE_LOG2    = 1,
    parameter int unsigned HILITE_OFFSET = 2,
    parameter logic [7:0]  CLEAR_CHAR    = 8'h20
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        write_valid_in,
    input  logic [9:0]  write_addr_in,
    input  logic [7:0]  write_data_in,
    input  logic [3:0]  ptr_index_in,
    input  logic [23:0] fg_color_in,
    input  logic [23:0] bg_color_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        active_draw_in,
    output logic [10:0] font_addr_out,
    input  logic [7:0]  font_data_in,
    output logic        busy_out,
    output logic [23:0] pixel_out,
    output logic        pixel_valid_out
);

    localparam int unsigned DEPTH      = TEXT_COLS * TEXT_ROWS;
    localparam int unsigned CELL_SHIFT = 3 + SCALE_LOG2;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    typedef struct packed {
        logic        valid;
        logic        hilite;
        logic [2:0]  px_bit;
        logic [23:0] fg;
        logic [23:0] bg;
    } stage_t;

    state_t      state;
    logic [9:0]  clr_addr;
    logic [7:0]  mem [DEPTH];
    logic [7:0]  char_q;
    stage_t      s1, s2, s3, s4;
    logic [2:0]  s1_grow;

    logic [10:0] col_c;
    logic [9:0]  trow_c;
    logic [2:0]  grow_c;
    logic [2:0]  bit_c;
    logic        in_window_c;
    logic [4:0]  hl_sum_c;
    logic        hilite_c;
    logic [9:0]  rd_addr_c;
    logic        wr_en_c;
    logic [9:0]  wr_addr_c;
    logic [7:0]  wr_data_c;
    logic        glyph_on_c;

    // Stage 0 raster mapping; entries are never valid while the clear runs
    always_comb begin
        col_c       = hcount_in >> CELL_SHIFT;
        trow_c      = vcount_in >> CELL_SHIFT;
        grow_c      = 3'(vcount_in >> SCALE_LOG2);
        bit_c       = 3'(hcount_in >> SCALE_LOG2);
        in_window_c = active_draw_in && !busy_out &&
                      (col_c < 11'(TEXT_COLS)) && (trow_c < 10'(TEXT_ROWS));
        hl_sum_c    = 5'(ptr_index_in) + 5'(HILITE_OFFSET);
        hilite_c    = (hl_sum_c < 5'(TEXT_ROWS)) && (trow_c == 10'(hl_sum_c));
        rd_addr_c   = '0;
        if (in_window_c) begin
            rd_addr_c = trow_c * 10'(TEXT_COLS) + 10'(col_c);
        end
    end

    // Write port: the clear sweep owns it while busy, host writes otherwise
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = write_addr_in;
        wr_data_c = write_data_in;
        if (!rst_in) begin
            if (state == ST_CLEAR) begin
                wr_en_c   = 1'b1;
                wr_addr_c = clr_addr;
                wr_data_c = CLEAR_CHAR;
            end else begin
                wr_en_c = write_valid_in && (write_addr_in < 10'(DEPTH));
            end
        end
    end

    // Read-first buffer: the raster sees the old code on a same-address write
    always_ff @(posedge clk_in) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
        char_q <= mem[rd_addr_c];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy_out <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 10'd1;
                    if (clr_addr == 10'(DEPTH - 1)) begin
                        state    <= ST_RUN;
                        busy_out <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign glyph_on_c = font_data_in[3'(3'd7 - s4.px_bit)] ^ s4.hilite;

    // Raster pipeline: S1 issues the font address, S2/S3 cover ROM latency
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1              <= '0;
            s2              <= '0;
            s3              <= '0;
            s4              <= '0;
            s1_grow         <= '0;
            font_addr_out   <= '0;
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
        end else begin
            s1.valid        <= in_window_c;
            s1.hilite       <= hilite_c;
            s1.px_bit       <= bit_c;
            s1.fg           <= fg_color_in;
            s1.bg           <= bg_color_in;
            s1_grow         <= grow_c;
            s2              <= s1;
            font_addr_out   <= {char_q, s1_grow};
            s3              <= s2;
            s4              <= s3;
            pixel_valid_out <= s4.valid;
            pixel_out       <= s4.valid ? (glyph_on_c ? s4.fg : s4.bg) : 24'h0;
        end
    end

endmodule

// File: tb/tb_menu_text_renderer.sv
// Directed bench for menu_text_renderer with a 2-cycle font ROM model.
module tb_menu_text_renderer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        write_valid_in;
    logic [9:0]  write_addr_in;
    logic [7:0]  write_data_in;
    logic [3:0]  ptr_index_in;
    logic [23:0] fg_color_in;
    logic [23:0] bg_color_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        active_draw_in;
    logic [10:0] font_addr_out;
    logic [7:0]  font_data_in;
    logic        busy_out;
    logic [23:0] pixel_out;
    logic        pixel_valid_out;

    logic [7:0]  rom_q;
    logic [7:0]  model [720];
    int          errors = 0;
    int          checks = 0;

    menu_text_renderer dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .write_valid_in  (write_valid_in),
        .write_addr_in   (write_addr_in),
        .write_data_in   (write_data_in),
        .ptr_index_in    (ptr_index_in),
        .fg_color_in     (fg_color_in),
        .bg_color_in     (bg_color_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .active_draw_in  (active_draw_in),
        .font_addr_out   (font_addr_out),
        .font_data_in    (font_data_in),
        .busy_out        (busy_out),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] glyph(input logic [7:0] code, input logic [2:0] row);
        if (code == 8'h20) return 8'h00;
        if (code == 8'h33) return 8'hF0;
        if (code == 8'h41) return (row == 3'd0) ? 8'h18 : 8'h24;
        return 8'hAA;
    endfunction

    // Font ROM: data valid two cycles after the address
    always @(posedge clk_in) begin
        rom_q        <= glyph(font_addr_out[10:3], font_addr_out[2:0]);
        font_data_in <= rom_q;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        @(negedge clk_in);
        write_valid_in = 1'b1;
        write_addr_in  = 10'(addr);
        write_data_in  = data;
        @(negedge clk_in);
        write_valid_in = 1'b0;
        if (addr < 720) model[addr] = data;
    endtask

    // One raster point; returns font address one cycle and pixel four cycles later
    task automatic probe(input int h, input int v, output logic [23:0] pix,
                         output logic vld, output logic vld_early, output logic [10:0] fa);
        @(negedge clk_in);
        hcount_in      = 11'(h);
        vcount_in      = 10'(v);
        active_draw_in = 1'b1;
        @(posedge clk_in); #1;
        active_draw_in = 1'b0;
        @(posedge clk_in); #1;
        fa = font_addr_out;
        repeat (2) @(posedge clk_in);
        #1 vld_early = pixel_valid_out;
        @(posedge clk_in); #1;
        pix = pixel_out;
        vld = pixel_valid_out;
    endtask

    task automatic scan(output int bad);
        logic [23:0] p;
        logic        v, ve;
        logic [10:0] fa;
        bad = 0;
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 80; c++) begin
                probe(c * 16, r * 16, p, v, ve, fa);
                if (fa[10:3] !== model[r * 80 + c] || v !== 1'b1) bad++;
            end
        end
    endtask

    task automatic busy_count(output int cnt);
        cnt = 0;
        while (busy_out === 1'b1 && cnt < 3000) begin
            @(posedge clk_in); #1;
            cnt++;
        end
    endtask

    initial begin
        logic [23:0] pix;
        logic        vld, vle;
        logic [10:0] fa;
        int          cnt, bad, vbad;

        rst_in = 1'b1; write_valid_in = 1'b0; write_addr_in = '0; write_data_in = '0;
        ptr_index_in = 4'd7; fg_color_in = 24'h123456; bg_color_in = 24'hABCDEF;
        hcount_in = '0; vcount_in = '0; active_draw_in = 1'b0;
        for (int i = 0; i < 720; i++) model[i] = 8'h20;

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_busy", 32'(busy_out), 32'd1);
        chk("rst_pixel", 32'(pixel_out), 32'd0);
        chk("rst_valid", 32'(pixel_valid_out), 32'd0);
        chk("rst_font_addr", 32'(font_addr_out), 32'd0);

        // Clear with a write held on and the raster active: both must be ignored
        @(negedge clk_in);
        rst_in = 1'b0; write_valid_in = 1'b1; write_addr_in = '0; write_data_in = 8'h41;
        active_draw_in = 1'b1;
        cnt = 0; vbad = 0;
        while (busy_out === 1'b1 && cnt < 3000) begin
            @(posedge clk_in); #1;
            cnt++;
            if (busy_out === 1'b1 && pixel_valid_out !== 1'b0) vbad++;
        end
        write_valid_in = 1'b0; active_draw_in = 1'b0;
        chk("clear_busy_cycles", 32'(cnt), 32'd720);
        chk("clear_no_valid", 32'(vbad), 32'd0);
        scan(bad);
        chk("clear_scan_bad", 32'(bad), 32'd0);

        // Glyph 'A' at row 2 col 59, no highlight
        wr(219, 8'h41);
        for (int b = 0; b < 8; b++) begin
            probe(59 * 16 + b * 2, 32, pix, vld, vle, fa);
            if (b == 0) chk("a_font_addr", 32'(fa), 32'({8'h41, 3'd0}));
            chk($sformatf("a_pix_bit%0d", b), 32'(pix),
                (b == 3 || b == 4) ? 32'h123456 : 32'hABCDEF);
        end

        // Latency and window boundaries
        probe(0, 0, pix, vld, vle, fa);
        chk("lat_early_valid", 32'(vle), 32'd0);
        chk("lat_valid", 32'(vld), 32'd1);
        probe(1280, 0, pix, vld, vle, fa);
        chk("col80_valid", 32'(vld), 32'd0);
        chk("col80_pixel", 32'(pix), 32'd0);
        probe(0, 144, pix, vld, vle, fa);
        chk("trow9_valid", 32'(vld), 32'd0);
        probe(1279, 143, pix, vld, vle, fa);
        chk("last_cell_valid", 32'(vld), 32'd1);
        chk("last_cell_pixel", 32'(pix), 32'hABCDEF);

        // Highlight: ptr 0 -> row 2
        wr(240, 8'h41);
        ptr_index_in = 4'd0; fg_color_in = 24'h88FFDD; bg_color_in = 24'h000000;
        probe(59 * 16 + 6, 32, pix, vld, vle, fa);
        chk("hl_row2_set", 32'(pix), 32'h000000);
        probe(59 * 16, 32, pix, vld, vle, fa);
        chk("hl_row2_clear", 32'(pix), 32'h88FFDD);
        probe(6, 48, pix, vld, vle, fa);
        chk("hl_row3_set", 32'(pix), 32'h88FFDD);
        probe(0, 48, pix, vld, vle, fa);
        chk("hl_row3_clear", 32'(pix), 32'h000000);
        ptr_index_in = 4'd1;
        probe(6, 48, pix, vld, vle, fa);
        chk("hl_ptr1_row3_set", 32'(pix), 32'h000000);
        ptr_index_in = 4'd7;
        probe(59 * 16 + 6, 32, pix, vld, vle, fa);
        chk("hl_ptr7_row2_set", 32'(pix), 32'h88FFDD);
        probe(1264, 128, pix, vld, vle, fa);
        chk("hl_ptr7_row8_clear", 32'(pix), 32'h000000);
        ptr_index_in = 4'd6;
        probe(1264, 128, pix, vld, vle, fa);
        chk("hl_ptr6_row8_clear", 32'(pix), 32'h88FFDD);

        // Out-of-range writes are dropped
        ptr_index_in = 4'd7; fg_color_in = 24'h123456; bg_color_in = 24'hABCDEF;
        wr(720, 8'h55);
        wr(1023, 8'h55);
        scan(bad);
        chk("oob_scan_bad", 32'(bad), 32'd0);

        // Same-cycle raster read and write at addr 299 (row 3 col 59)
        @(negedge clk_in);
        write_valid_in = 1'b1; write_addr_in = 10'd299; write_data_in = 8'h33;
        hcount_in = 11'(59 * 16); vcount_in = 10'd48; active_draw_in = 1'b1;
        @(posedge clk_in); #1;
        write_valid_in = 1'b0; active_draw_in = 1'b0;
        model[299] = 8'h33;
        @(posedge clk_in); #1;
        chk("rw_font_addr_old", 32'(font_addr_out), 32'({8'h20, 3'd0}));
        repeat (3) @(posedge clk_in);
        #1 chk("rw_pixel_old", 32'(pixel_out), 32'hABCDEF);
        probe(59 * 16, 48, pix, vld, vle, fa);
        chk("rw_font_addr_new", 32'(fa), 32'({8'h33, 3'd0}));
        chk("rw_pixel_new", 32'(pix), 32'h123456);

        // Reset during clear restarts the sweep
        @(negedge clk_in); rst_in = 1'b1;
        @(negedge clk_in); rst_in = 1'b0;
        repeat (400) @(posedge clk_in);
        @(negedge clk_in); rst_in = 1'b1;
        chk("midrst_busy_pre", 32'(busy_out), 32'd1);
        repeat (2) @(posedge clk_in);
        #1 chk("midrst_busy_held", 32'(busy_out), 32'd1);
        @(negedge clk_in); rst_in = 1'b0;
        busy_count(cnt);
        chk("midrst_busy_cycles", 32'(cnt), 32'd720);
        for (int i = 0; i < 720; i++) model[i] = 8'h20;
        scan(bad);
        chk("midrst_scan_bad", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
